// File: rtl/output_tile_sequencer_if.sv
// Handshake bundle for output_tile_sequencer: tile command, accumulator control,
// accumulator read port and the 64-bit output stream towards the DMA.
interface output_tile_sequencer_if #(
  parameter int ADDR_W = 10,
  parameter int K_W    = 16
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [K_W-1:0]    cmd_k_tiles;
  logic              sys_valid;
  logic              acc_valid;
  logic              acc_clear;
  logic              tile_done;
  logic              dma_rd_en;
  logic [ADDR_W-1:0] dma_rd_addr;
  logic [63:0]       dma_rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [63:0]       out_data;
  logic              out_last;
  logic              busy;
  logic [15:0]       tiles_done;

  modport master (
    input  cmd_valid, cmd_k_tiles, sys_valid, dma_rd_data, out_ready,
    output cmd_ready, acc_valid, acc_clear, tile_done, dma_rd_en, dma_rd_addr,
           out_valid, out_data, out_last, busy, tiles_done
  );

  modport slave (
    output cmd_valid, cmd_k_tiles, sys_valid, dma_rd_data, out_ready,
    input  cmd_ready, acc_valid, acc_clear, tile_done, dma_rd_en, dma_rd_addr,
           out_valid, out_data, out_last, busy, tiles_done
  );
endinterface

// File: rtl/output_tile_sequencer.sv
// Double-buffered accumulator sequencer: clear/accumulate/swap one tile while draining the previous
// bank; reads land RD_LAT later in a fall-through skid FIFO, issue is credit-gated so out_ready stalls never overflow it.
module output_tile_sequencer #(
  parameter int ADDR_W = 10,
  parameter int K_W    = 16,
  parameter int WORDS  = 32,
  parameter int RD_LAT = 2,
  parameter int FIFO_D = 4
) (
  input  logic clk,
  input  logic rst_n,
  output_tile_sequencer_if.master bus
);
  localparam int PTR_W = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
  localparam int CNT_W = $clog2(FIFO_D + RD_LAT + 1);

  typedef enum logic [1:0] {A_IDLE, A_CLEAR, A_ACCUM, A_SWAP} a_state_t;
  typedef enum logic [1:0] {D_IDLE, D_RUN, D_FLUSH} d_state_t;

  typedef struct packed {
    logic        last;
    logic [63:0] data;
  } fifo_ent_t;

  a_state_t          a_state;
  d_state_t          d_state;
  logic [K_W-1:0]    k_tiles;
  logic [K_W-1:0]    k_cnt;
  logic [ADDR_W-1:0] rd_addr;
  logic [RD_LAT-1:0] pipe_vld;
  logic [RD_LAT-1:0] pipe_last;
  fifo_ent_t         fifo_mem [FIFO_D];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  inflight_cnt;
  logic [15:0]       tiles_done_q;

  logic      acc_pulse;
  logic      swap_go;
  logic      credit_ok;
  logic      rd_en;
  logic      rd_is_last;
  logic      push;
  logic      pop;
  logic      fifo_nonempty;
  logic      last_hs;
  fifo_ent_t head;

  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight_cnt = inflight_cnt + CNT_W'(pipe_vld[i]);
    end
  end

  // Pops in the same cycle are not credited back, keeping the check purely registered.
  assign credit_ok     = (fifo_count + inflight_cnt) < CNT_W'(FIFO_D);
  assign acc_pulse     = (a_state == A_ACCUM) && bus.sys_valid;
  assign swap_go       = (a_state == A_SWAP) && (d_state == D_IDLE);
  assign rd_en         = (d_state == D_RUN) && credit_ok;
  assign rd_is_last    = (rd_addr == ADDR_W'(WORDS - 1));
  assign fifo_nonempty = (fifo_count != '0);
  assign head          = fifo_mem[rd_ptr];
  assign push          = pipe_vld[RD_LAT-1];
  assign pop           = fifo_nonempty && bus.out_ready;
  assign last_hs       = pop && head.last;

  // Accumulate side
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_state <= A_IDLE;
      k_tiles <= '0;
      k_cnt   <= '0;
    end else begin
      case (a_state)
        A_IDLE: begin
          if (bus.cmd_valid) begin
            k_tiles <= bus.cmd_k_tiles;
            k_cnt   <= '0;
            a_state <= A_CLEAR;
          end
        end
        A_CLEAR: a_state <= (k_tiles == '0) ? A_SWAP : A_ACCUM;
        A_ACCUM: begin
          if (bus.sys_valid) begin
            k_cnt <= k_cnt + K_W'(1);
            if (k_cnt + K_W'(1) == k_tiles) a_state <= A_SWAP;
          end
        end
        A_SWAP: begin
          if (d_state == D_IDLE) a_state <= A_IDLE;
        end
        default: a_state <= A_IDLE;
      endcase
    end
  end

  // Drain side: issue reads, then wait for the tagged last word to leave.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_state      <= D_IDLE;
      rd_addr      <= '0;
      tiles_done_q <= '0;
    end else begin
      case (d_state)
        D_IDLE: begin
          if (swap_go) begin
            d_state <= D_RUN;
            rd_addr <= '0;
          end
        end
        D_RUN: begin
          if (rd_en) begin
            if (rd_is_last) begin
              rd_addr <= '0;
              d_state <= D_FLUSH;
            end else begin
              rd_addr <= rd_addr + ADDR_W'(1);
            end
          end
        end
        D_FLUSH: begin
          if (last_hs) begin
            d_state      <= D_IDLE;
            tiles_done_q <= tiles_done_q + 16'd1;
          end
        end
        default: d_state <= D_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld  <= '0;
      pipe_last <= '0;
    end else begin
      pipe_vld[0]  <= rd_en;
      pipe_last[0] <= rd_en && rd_is_last;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_last[i] <= pipe_last[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_W'(FIFO_D - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= (rd_ptr == PTR_W'(FIFO_D - 1)) ? '0 : rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{last: pipe_last[RD_LAT-1], data: bus.dma_rd_data};
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (fifo_count == CNT_W'(FIFO_D))));

  assign bus.cmd_ready   = (a_state == A_IDLE);
  assign bus.acc_clear   = (a_state == A_CLEAR);
  assign bus.acc_valid   = acc_pulse;
  assign bus.tile_done   = swap_go;
  assign bus.dma_rd_en   = rd_en;
  assign bus.dma_rd_addr = rd_addr;
  assign bus.out_valid   = fifo_nonempty;
  assign bus.out_data    = fifo_nonempty ? head.data : 64'd0;
  assign bus.out_last    = fifo_nonempty && head.last;
  assign bus.busy        = (a_state != A_IDLE) || (d_state != D_IDLE) || fifo_nonempty;
  assign bus.tiles_done  = tiles_done_q;
endmodule

// File: tb/tb_output_tile_sequencer.sv
// Scoreboarded bench for output_tile_sequencer: expected words are queued on each tile_done
// and compared in order as the output stream handshakes.
module tb_output_tile_sequencer;
  localparam int ADDR_W = 10;
  localparam int K_W    = 16;
  localparam int WORDS  = 32;
  localparam int RD_LAT = 2;
  localparam int FIFO_D = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  output_tile_sequencer_if #(.ADDR_W(ADDR_W), .K_W(K_W)) bus ();

  output_tile_sequencer #(
    .ADDR_W(ADDR_W), .K_W(K_W), .WORDS(WORDS), .RD_LAT(RD_LAT), .FIFO_D(FIFO_D)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] word_val(input int tag, input int addr);
    return {16'hC0DE, 16'(tag), 16'(addr) ^ 16'h5A5A, 16'(addr)};
  endfunction

  // Monitor bookkeeping
  logic [64:0] exp_q[$];
  int n_clear = 0, n_acc = 0, n_done = 0, last_cnt = 0;
  int words_out = 0, rd_issued = 0, max_out = 0, exp_addr = 0;
  logic prev_stall = 1'b0;
  logic [63:0] prev_data = '0;

  // Accumulator read model, RD_LAT=2 registered stages
  logic [63:0] rd_p0, rd_p1;
  always @(posedge clk) begin
    rd_p0 <= bus.dma_rd_en ? word_val(n_done, int'(bus.dma_rd_addr)) : 64'd0;
    rd_p1 <= rd_p0;
  end
  assign bus.dma_rd_data = rd_p1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.acc_clear) n_clear++;
      if (bus.acc_valid) n_acc++;
      if (bus.tile_done) begin
        chk("done_after_drain", 64'(last_cnt), 64'(n_done));
        n_done++;
        for (int a = 0; a < WORDS; a++) exp_q.push_back({(a == WORDS - 1), word_val(n_done, a)});
      end
      if (bus.dma_rd_en) begin
        chk("rd_addr", 64'(bus.dma_rd_addr), 64'(exp_addr));
        exp_addr = (exp_addr + 1) % WORDS;
        rd_issued++;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_nonempty", 64'(exp_q.size()), 64'd1);
        end else begin
          logic [64:0] e;
          e = exp_q.pop_front();
          chk("out_data", bus.out_data, e[63:0]);
          chk("out_last", 64'(bus.out_last), 64'(e[64]));
        end
        words_out++;
        if (bus.out_last) last_cnt++;
      end
      if (rd_issued - words_out > max_out) max_out = rd_issued - words_out;
      if (prev_stall && bus.out_valid) chk("stall_stable", bus.out_data, prev_data);
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input int k);
    logic acc;
    acc = 1'b0;
    bus.cmd_valid   = 1'b1;
    bus.cmd_k_tiles = K_W'(k);
    for (int i = 0; i < 500 && !acc; i++) begin
      acc = bus.cmd_ready;
      step(1);
    end
    bus.cmd_valid = 1'b0;
    chk("cmd_accepted", 64'(acc), 64'd1);
  endtask

  task automatic pulse_sys();
    bus.sys_valid = 1'b1;
    step(1);
    bus.sys_valid = 1'b0;
  endtask

  task automatic wait_tiles(input int target);
    for (int i = 0; i < 3000 && int'(bus.tiles_done) != target; i++) step(1);
    chk("tiles_done", 64'(bus.tiles_done), 64'(target));
  endtask

  task automatic wait_words(input int target);
    for (int i = 0; i < 3000 && words_out < target; i++) step(1);
    chk("words_reached", 64'(words_out), 64'(target));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_status"}, 64'({bus.cmd_ready, bus.acc_valid, bus.acc_clear, bus.tile_done,
                                bus.dma_rd_en, bus.out_valid, bus.out_last, bus.busy}), 64'h80);
    chk({tag, "_addr"}, 64'(bus.dma_rd_addr), 64'd0);
    chk({tag, "_data"}, bus.out_data, 64'd0);
    chk({tag, "_tiles"}, 64'(bus.tiles_done), 64'd0);
  endtask

  initial begin
    int c0, a0, d0, w0;
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_k_tiles = '0;
    bus.sys_valid = 1'b0;
    bus.out_ready = 1'b1;
    #23;
    check_reset_outputs("reset");
    step(1);
    rst_n = 1'b1;
    step(2);

    // k=3, three partial sums two cycles apart
    c0 = n_clear; a0 = n_acc; d0 = n_done; w0 = words_out;
    send_cmd(3);
    step(1);
    for (int p = 0; p < 3; p++) begin
      pulse_sys();
      step(1);
    end
    wait_tiles(1);
    step(2);
    chk("t1_clear", 64'(n_clear - c0), 64'd1);
    chk("t1_acc", 64'(n_acc - a0), 64'd3);
    chk("t1_done", 64'(n_done - d0), 64'd1);
    chk("t1_words", 64'(words_out - w0), 64'(WORDS));
    chk("t1_busy", 64'(bus.busy), 64'd0);

    // 20-cycle stall mid-drain
    w0 = words_out; max_out = 0;
    send_cmd(1);
    step(1);
    pulse_sys();
    wait_words(w0 + 8);
    bus.out_ready = 1'b0;
    step(20);
    bus.out_ready = 1'b1;
    wait_tiles(2);
    step(2);
    chk("t2_max_outstanding_ok", 64'(max_out <= FIFO_D), 64'd1);
    chk("t2_words", 64'(words_out - w0), 64'(WORDS));

    // Back-to-back tiles with the stream blocked; sys_valid held during A_SWAP
    a0 = n_acc; d0 = n_done; w0 = words_out;
    bus.out_ready = 1'b0;
    send_cmd(1);
    step(1);
    pulse_sys();
    send_cmd(1);
    step(1);
    pulse_sys();
    bus.sys_valid = 1'b1;
    step(10);
    bus.sys_valid = 1'b0;
    chk("t3_done_withheld", 64'(n_done - d0), 64'd1);
    chk("t3_acc", 64'(n_acc - a0), 64'd2);
    chk("t3_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    chk("t3_busy", 64'(bus.busy), 64'd1);
    bus.out_ready = 1'b1;
    wait_tiles(4);
    step(2);
    chk("t3_done", 64'(n_done - d0), 64'd2);
    chk("t3_words", 64'(words_out - w0), 64'(2 * WORDS));

    // sys_valid while idle is ignored
    a0 = n_acc;
    bus.sys_valid = 1'b1;
    step(5);
    bus.sys_valid = 1'b0;
    step(1);
    chk("idle_sys_ignored", 64'(n_acc - a0), 64'd0);

    // k=0: clear, then tile_done on the very next cycle
    a0 = n_acc; w0 = words_out;
    send_cmd(0);
    chk("k0_clear", 64'(bus.acc_clear), 64'd1);
    step(1);
    chk("k0_tile_done", 64'(bus.tile_done), 64'd1);
    wait_tiles(5);
    step(2);
    chk("k0_acc", 64'(n_acc - a0), 64'd0);
    chk("k0_words", 64'(words_out - w0), 64'(WORDS));

    // Reset at word 10 of a drain
    w0 = words_out;
    send_cmd(1);
    step(1);
    pulse_sys();
    wait_words(w0 + 10);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    last_cnt = n_done; rd_issued = 0; words_out = 0; exp_addr = 0;
    prev_stall = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(1);
    c0 = n_clear; a0 = n_acc;
    send_cmd(2);
    step(1);
    pulse_sys();
    step(1);
    pulse_sys();
    wait_tiles(1);
    step(2);
    chk("post_rst_clear", 64'(n_clear - c0), 64'd1);
    chk("post_rst_acc", 64'(n_acc - a0), 64'd2);
    chk("post_rst_words", 64'(words_out), 64'(WORDS));
    chk("post_rst_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
